// File: rtl/mux_nbit_x4_rr.sv
// mux_nbit_x4_rr: 4:1 round-robin merge of valid/ready streams into one
// single-entry registered output stage.
//
// Ports:
//   clk                       sole clock, rising edge
//   reset                     synchronous active-high reset
//   a, b, c, d                source data, channels 0..3
//   a_valid .. d_valid        source word present
//   a_ready .. d_ready        source word accepted this cycle (combinational)
//   y                         merged output data (registered)
//   sel                       index of channel that produced y (registered)
//   y_valid                   y/sel hold a word (registered state)
//   y_ready                   sink accepts y this cycle
module mux_nbit_x4_rr #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic                 a_valid,
    input  logic                 b_valid,
    input  logic                 c_valid,
    input  logic                 d_valid,
    output logic                 a_ready,
    output logic                 b_ready,
    output logic                 c_ready,
    output logic                 d_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [1:0]           sel,
    output logic                 y_valid,
    input  logic                 y_ready
);

    localparam int unsigned N_CH  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] y_q, y_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    logic [N_CH-1:0]      valid_vec;
    logic [BUS_WIDTH-1:0] data_arr [N_CH];
    logic                 grant_found_c;
    logic [IDX_W-1:0]     grant_idx_c;
    logic                 load_en_c;
    logic [N_CH-1:0]      ready_c;

    assign valid_vec = {d_valid, c_valid, b_valid, a_valid};

    always_comb begin
        data_arr[0] = a;
        data_arr[1] = b;
        data_arr[2] = c;
        data_arr[3] = d;
    end

    // Round-robin search starting at ptr_q; 2-bit index arithmetic wraps 3 -> 0.
    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!grant_found_c && valid_vec[ptr_q + IDX_W'(k)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = ptr_q + IDX_W'(k);
            end
        end
    end

    // Output stage can take a word when empty or being drained this cycle.
    assign load_en_c = (state_q == EMPTY) || y_ready;

    // Only the granted channel sees ready; reset suppresses all consumption.
    always_comb begin
        ready_c = '0;
        if (grant_found_c && load_en_c && !reset) begin
            ready_c = N_CH'(1) << grant_idx_c;
        end
    end

    assign a_ready = ready_c[0];
    assign b_ready = ready_c[1];
    assign c_ready = ready_c[2];
    assign d_ready = ready_c[3];

    // Next-state: load a granted word, or go empty when drained with nothing to take.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load_en_c) begin
            if (grant_found_c) begin
                state_d = FULL;
                y_d     = data_arr[grant_idx_c];
                sel_d   = grant_idx_c;
                ptr_d   = grant_idx_c + IDX_W'(1);
            end else begin
                state_d = EMPTY;
            end
        end
    end

    // State and output registers; reset overrides any load or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            y_q     <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign y       = y_q;
    assign sel     = sel_q;
    assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_nbit_x4_rr.sv
// Bench for mux_nbit_x4_rr: directed vectors, expected output words queued
// by the stimulus and popped by a monitor on every output transfer.
module tb_mux_nbit_x4_rr;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] y;
        logic [1:0]   sel;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b, c, d;
    logic         a_valid, b_valid, c_valid, d_valid;
    logic         a_ready, b_ready, c_ready, d_ready;
    logic [W-1:0] y;
    logic [1:0]   sel;
    logic         y_valid;
    logic         y_ready;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    mux_nbit_x4_rr #(.BUS_WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .c_valid (c_valid),
        .d_valid (d_valid),
        .a_ready (a_ready),
        .b_ready (b_ready),
        .c_ready (c_ready),
        .d_ready (d_ready),
        .y       (y),
        .sel     (sel),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic [W-1:0] dc, input logic [W-1:0] dd, input logic yr);
        {d_valid, c_valid, b_valid, a_valid} = v;
        a = da;
        b = db;
        c = dc;
        d = dd;
        y_ready = yr;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] ey, input logic [1:0] es);
        exp_t e;
        e.y   = ey;
        e.sel = es;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] rdy();
        return 32'({d_ready, c_ready, b_ready, a_ready});
    endfunction

    // Monitor: every accepted output word must match the head of the scoreboard.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && y_valid && y_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: actual y=%0h sel=%0d required no word", y, sel);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_y", 32'(y), 32'(e.y));
                    chk("sb_sel", 32'(sel), 32'(e.sel));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset with every source valid: nothing may be consumed.
        reset = 1'b1;
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        @(negedge clk);
        chk("rst_ready", rdy(), 32'h0);
        step();
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_y_valid", 32'(y_valid), 32'h0);

        // Single b word.
        reset = 1'b0;
        drive(4'b0010, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b1);
        push(8'h5A, 2'd1);
        @(negedge clk);
        chk("b_ready", rdy(), 32'h2);
        step();
        chk("b_y_valid", 32'(y_valid), 32'h1);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        // Drained with nothing pending: empty, y/sel retained.
        chk("drain_y_valid", 32'(y_valid), 32'h0);
        chk("drain_y", 32'(y), 32'h5A);
        chk("drain_sel", 32'(sel), 32'h1);

        // Pointer now 2: c beats a.
        drive(4'b0101, 8'hA1, 8'h00, 8'hC3, 8'h00, 1'b1);
        push(8'hC3, 2'd2);
        @(negedge clk);
        chk("ptr2_ready", rdy(), 32'h4);
        step();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        chk("ptr2_drain", 32'(y_valid), 32'h0);

        // Fresh reset, then all four held valid: strict a,b,c,d,a,b.
        reset = 1'b1;
        drive(4'hF, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        @(negedge clk);
        chk("rst2_ready", rdy(), 32'h0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push(8'(k % 4 + 1), 2'(k % 4));
            @(negedge clk);
            chk("rr_ready", rdy(), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_y_valid", 32'(y_valid), 32'h1);
            step();
        end
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        chk("rr_last_valid", 32'(y_valid), 32'h1);
        step();
        chk("rr_drain", 32'(y_valid), 32'h0);

        // Backpressure: y=11 held while a offers 22.
        drive(4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1);
        push(8'h11, 2'd0);
        @(negedge clk);
        chk("bp_load_ready", rdy(), 32'h1);
        step();
        drive(4'b0001, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", rdy(), 32'h0);
            chk("bp_hold_y", 32'(y), 32'h11);
            step();
        end
        y_ready = 1'b1;
        push(8'h22, 2'd0);
        @(negedge clk);
        chk("bp_release_ready", rdy(), 32'h1);
        step();
        chk("bp_new_y", 32'(y), 32'h22);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();

        // Grant d (pointer wraps to 0), then a before c.
        drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'hDD, 1'b1);
        push(8'hDD, 2'd3);
        @(negedge clk);
        chk("wrap_d_ready", rdy(), 32'h8);
        step();
        drive(4'b0101, 8'hAA, 8'h00, 8'hCC, 8'h00, 1'b1);
        push(8'hAA, 2'd0);
        @(negedge clk);
        chk("wrap_a_ready", rdy(), 32'h1);
        step();
        push(8'hCC, 2'd2);
        @(negedge clk);
        chk("wrap_c_ready", rdy(), 32'h4);
        step();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();

        // Load c while empty (y_ready ignored), then reset while full and stalled.
        drive(4'b0100, 8'h00, 8'h00, 8'h33, 8'h00, 1'b1);
        @(negedge clk);
        chk("pre_rst_ready", rdy(), 32'h4);
        step();
        chk("pre_rst_y", 32'(y), 32'h33);
        drive(4'b0100, 8'h00, 8'h00, 8'h44, 8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("full_rst_ready", rdy(), 32'h0);
        step();
        chk("full_rst_y", 32'(y), 32'h0);
        chk("full_rst_sel", 32'(sel), 32'h0);
        chk("full_rst_y_valid", 32'(y_valid), 32'h0);
        reset = 1'b0;
        push(8'h44, 2'd2);
        @(negedge clk);
        chk("post_rst_ready", rdy(), 32'h4);
        step();
        chk("post_rst_y", 32'(y), 32'h44);
        chk("post_rst_sel", 32'(sel), 32'h2);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        step();

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
